// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^W) constants, FSM state type and xtime helper
package gf_pkg;

  localparam logic [8:0] AES_POLY  = 9'h11B;
  localparam logic [4:0] GF16_POLY = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply v by x in GF(2^w); poly carries the low w bits of the
  // reduction polynomial (the x^w term is implied by the shifted-out MSB).
  function automatic logic [15:0] gf_xtime(input logic [15:0] v,
                                           input logic [15:0] poly,
                                           input int w);
    logic [15:0] r;
    logic [15:0] mask;
    r    = '0;
    mask = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    for (int i = 1; i < 16; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    if (v[4'(w - 1)]) r = r ^ (poly & mask);
    return r;
  endfunction

endpackage

// File: rtl/gf_xtime_n.sv
// rtl/gf_xtime_n.sv - one Horner step: xtime(acc) ^ (sel ? a : 0)
module gf_xtime_n
  import gf_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = 9'h11B
) (
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] a,
  input  logic         sel,
  output logic [W-1:0] acc_out
);

  logic [15:0] unused_x;

  // Double the running value, then fold in the multiplicand if this bit is set
  always_comb begin
    unused_x = gf_xtime(16'(acc_in), 16'(POLY[W-1:0]), W);
    acc_out  = unused_x[W-1:0] ^ (sel ? a : '0);
  end

endmodule

// File: rtl/gf_mult_iter.sv
// rtl/gf_mult_iter.sv - iterative LANES x GF(2^W) multiplier, STEP bits per cycle
module gf_mult_iter
  import gf_pkg::*;
#(
  parameter int         W     = 8,
  parameter logic [W:0] POLY  = 9'h11B,
  parameter int         LANES = 4,
  parameter int         STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [W-1:0]         in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_p
);

  localparam int             CW       = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_INC  = CW'(STEP);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - STEP);

  state_t               state;
  logic [LANES*W-1:0]   a_reg;
  logic [W-1:0]         b_reg;
  logic [LANES*W-1:0]   acc;
  logic [LANES*W-1:0]   acc_next;
  logic [CW-1:0]        cnt;

  // b_reg is shifted left every cycle so the next multiplier bits to
  // consume are always at the top; step s of a cycle uses b_reg[W-1-s].
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar s = 0; s < STEP; s++) begin : g_step
      logic [W-1:0] x;
      logic [W-1:0] y;
      if (s == 0) begin : g_first
        assign x = acc[l*W +: W];
      end else begin : g_chain
        assign x = g_step[s-1].y;
      end
      gf_xtime_n #(.W(W), .POLY(POLY)) u_xt (
        .acc_in  (x),
        .a       (a_reg[l*W +: W]),
        .sel     (b_reg[W-1-s]),
        .acc_out (y)
      );
    end
    assign acc_next[l*W +: W] = g_step[STEP-1].y;
  end

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  // Control FSM: accept operands, iterate over multiplier bits, hold result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_reg << STEP;
          cnt   <= cnt + CNT_INC;
          if (cnt == CNT_LAST) begin
            out_p     <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg <= in_a;
              b_reg <= in_b;
              acc   <= '0;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mult_iter.sv
// tb/tb_gf_mult_iter.sv - self-checking bench for gf_mult_iter
module tb_gf_mult_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iv, orr, ir, ov;
  logic [31:0] ina;
  logic [7:0]  inb;
  logic [31:0] op [4];

  logic        c_iv, c_ir, c_ov, c_or;
  logic [7:0]  c_a, c_p;
  logic [3:0]  c_b;

  int errors = 0;
  int checks = 0;

  int          sent, recvd, lat;
  logic        took;
  logic [31:0] q [$];
  logic [31:0] ra, pa, qa, exp1, p;
  logic [7:0]  rb, pb, qb, p4;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    gf_mult_iter #(.W(8), .POLY(9'h11B), .LANES(4), .STEP(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_a      (ina),
      .in_b      (inb),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_p     (op[g])
    );
  end

  gf_mult_iter #(.W(4), .POLY(5'h13), .LANES(2), .STEP(1)) u_w4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (c_iv),
    .in_ready  (c_ir),
    .in_a      (c_a),
    .in_b      (c_b),
    .out_valid (c_ov),
    .out_ready (c_or),
    .out_p     (c_p)
  );

  // Reference: carry-less schoolbook product, then polynomial long division
  function automatic int gmul(int a, int b, int w, int poly);
    int pr = 0;
    for (int i = 0; i < w; i++)
      if (((b >> i) & 1) != 0) pr ^= a << i;
    for (int i = 2 * w - 2; i >= w; i--)
      if (((pr >> i) & 1) != 0) pr ^= poly << (i - w);
    return pr;
  endfunction

  function automatic logic [31:0] mul4(logic [31:0] a, logic [7:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++)
      r[l*8 +: 8] = 8'(gmul(int'(a[l*8 +: 8]), int'(b), 8, 'h11B));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    iv  = 4'h0;
    orr = 4'hF;
    repeat (12) @(posedge clk);
    @(negedge clk);
    orr = 4'h0;
  endtask

  // One operation on all four STEP variants at once; checks latency and products
  task automatic run_op8(input logic [31:0] a, input logic [7:0] b, output logic [31:0] p0);
    int          lt [4];
    logic [31:0] expv;
    expv = mul4(a, b);
    for (int g = 0; g < 4; g++) lt[g] = 0;
    @(negedge clk);
    ina = a;
    inb = b;
    iv  = 4'hF;
    orr = 4'h0;
    #1 chk("in_ready_idle", ir, 4'hF);
    @(posedge clk);
    @(negedge clk);
    iv = 4'h0;
    for (int e = 2; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++)
        if (lt[g] == 0 && ov[g]) lt[g] = e;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("latency_step%0d", 1 << g), lt[g], (8 >> g) + 1);
      chk($sformatf("product_step%0d", 1 << g), op[g], expv);
    end
    p0  = op[0];
    orr = 4'hF;
    @(posedge clk);
    @(negedge clk);
    orr = 4'h0;
    chk("drained", ov, 4'h0);
  endtask

  task automatic run_w4(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] b,
                        output logic [7:0] pr);
    int lt;
    lt = 0;
    @(negedge clk);
    c_a  = {a1, a0};
    c_b  = b;
    c_iv = 1'b1;
    c_or = 1'b0;
    #1 chk("w4_in_ready", c_ir, 1);
    @(posedge clk);
    @(negedge clk);
    c_iv = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (lt == 0 && c_ov) lt = e;
    end
    chk("w4_latency", lt, 5);
    chk("w4_product", c_p, {4'(gmul(int'(a1), int'(b), 4, 'h13)), 4'(gmul(int'(a0), int'(b), 4, 'h13))});
    pr   = c_p;
    c_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_or = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 4'h0; orr = 4'h0; ina = '0; inb = '0;
    c_iv = 1'b0; c_or = 1'b0; c_a = '0; c_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", ir, 4'hF);
    chk("reset_out_valid", ov, 4'h0);
    chk("reset_out_p", op[0], 0);
    chk("reset_w4_ready", c_ir, 1);
    chk("reset_w4_valid", c_ov, 0);

    // AES reference vectors
    run_op8(32'hFF000157, 8'h83, p);
    chk("aes_57x83", p[7:0], 8'hC1);
    chk("aes_01x83", p[15:8], 8'h83);
    chk("aes_00x83", p[23:16], 8'h00);
    run_op8(32'h0E0D0957, 8'h13, p);
    chk("aes_57x13", p[7:0], 8'hFE);
    run_op8(32'hB2B2B2B2, 8'h02, p);
    chk("aes_b2x02", p, 32'h7F7F7F7F);
    run_op8(32'h80FF0102, 8'hFF, p);
    run_op8(32'h12345678, 8'h00, p);
    for (int k = 0; k < 20; k++) run_op8($urandom, 8'($urandom), p);

    // GF(16)
    run_w4(4'h3, 4'h0, 4'h7, p4);
    chk("gf16_3x7", p4[3:0], 4'h9);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_w4(4'(a), 4'(15 - a), 4'(b), p4);

    // Backpressure in DONE, then back-to-back consume + accept
    pa = $urandom; pb = 8'($urandom);
    qa = $urandom; qb = 8'($urandom);
    exp1 = mul4(pa, pb);
    @(negedge clk);
    ina = pa; inb = pb; iv = 4'hF; orr = 4'h0;
    @(posedge clk);
    @(negedge clk);
    iv = 4'h0;
    for (int e = 0; e < 20 && !ov[0]; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_valid_seen", ov[0], 1);
    for (int k = 0; k < 5; k++) begin
      ina = $urandom; inb = 8'($urandom); iv = 4'hF;
      #1;
      chk("bp_out_valid", ov[0], 1);
      chk("bp_out_p", op[0], exp1);
      chk("bp_in_ready", ir[0], 0);
      @(posedge clk);
      @(negedge clk);
    end
    ina = qa; inb = qb; iv = 4'hF; orr = 4'hF;
    #1 chk("b2b_in_ready", ir[0], 1);
    @(posedge clk);
    @(negedge clk);
    iv = 4'h0; orr = 4'h0;
    chk("b2b_out_valid_low", ov[0], 0);
    chk("b2b_running", ir[0], 0);
    lat = 1;
    for (int e = 0; e < 20 && !ov[0]; e++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", lat, 9);
    chk("b2b_product", op[0], mul4(qa, qb));
    drain();

    // Reset during RUN
    @(negedge clk);
    ina = $urandom; inb = 8'($urandom); iv = 4'hF;
    @(posedge clk);
    @(negedge clk);
    iv = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run_valid", ov[0], 0);
    chk("rst_run_ready", ir[0], 1);

    // Reset in DONE
    @(negedge clk);
    ina = 32'hA5A5A5A5; inb = 8'h5A; iv = 4'hF;
    @(posedge clk);
    @(negedge clk);
    iv = 4'h0;
    for (int e = 0; e < 20 && !ov[0]; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_done_pre", op[0], mul4(32'hA5A5A5A5, 8'h5A));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_done_valid", ov[0], 0);
    chk("rst_done_ready", ir[0], 1);
    chk("rst_done_out_p", op[0], 0);
    run_op8(32'h00000057, 8'h83, p);
    chk("post_rst_57x83", p[7:0], 8'hC1);

    // Random stream with stalls on the STEP=8 variant, scoreboarded
    sent = 0; recvd = 0; took = 1'b0;
    for (int cyc = 0; cyc < 60000 && recvd < 10000; cyc++) begin
      @(negedge clk);
      if (took) iv[3] = 1'b0;
      if (!iv[3] && sent < 10000 && $urandom_range(0, 7) != 0) begin
        ra = $urandom; rb = 8'($urandom);
        ina = ra; inb = rb; iv[3] = 1'b1;
      end
      orr[3] = ($urandom_range(0, 3) != 0);
      #1;
      took = iv[3] && ir[3];
      if (ov[3] && orr[3]) begin
        chk("rnd_no_extra", q.size() > 0, 1);
        if (q.size() > 0) chk("rnd_product", op[3], q.pop_front());
        recvd++;
      end
      if (took) begin
        q.push_back(mul4(ra, rb));
        sent++;
      end
    end
    @(negedge clk);
    iv = 4'h0; orr = 4'h0;
    chk("rnd_received", recvd, 10000);
    chk("rnd_sent_eq_recv", sent, recvd);
    chk("rnd_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
